ula_arbiter: RTL and testbench
==============================

ULA_ARBITER -- requirements
Module: ula_arbiter

Interface
REQ-001 Parameter W, default 64, operand/result width; SHALL match the shared ALU width.
REQ-002 Parameter CNT_W, default 16, grant-counter width (used only with ULA_ARB_STATS_EN).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req0_valid/req1_valid  input  1 each  requester N has an operation pending.
REQ-006 req0_ready/req1_ready  output  1 each  requester N granted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  W each  operands.
REQ-008 req0_op/req1_op  input  4 each  ALU op code (4'b0110 = subtract, else add).
REQ-009 ula_a, ula_b  output  W each  operands driven to the shared ALU.
REQ-010 ula_op  output  4  op driven to the shared ALU.
REQ-011 ula_result  input  W, ula_flags  input  6  combinational ALU outputs (bit0 BEQ .. bit5 BGEU).
REQ-012 rsp_valid  output  1, rsp_ready  input  1  response handshake.
REQ-013 rsp_id  output  1  requester that issued the response; rsp_result  output  W; rsp_flags  output  6.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP.
REQ-015 IDLE: at most one reqN_ready high per cycle, combinational from valids and rr pointer; no ready outside IDLE.
REQ-016 Only one valid: that requester granted regardless of pointer.
REQ-017 Both valid: requester equal to rr pointer granted; pointer then set to the other requester.
REQ-018 Grant (valid&ready): a, b, op, id registered; IDLE->EXEC.
REQ-019 EXEC: ula_a/ula_b/ula_op driven from registered operands; ula_result/ula_flags captured into rsp_result/rsp_flags at end of cycle; EXEC->RESP.
REQ-020 RESP: rsp_valid=1; rsp_id/rsp_result/rsp_flags SHALL stay stable until rsp_ready; rsp_valid&rsp_ready -> IDLE.
REQ-021 Latency: grant in cycle N -> rsp_valid in cycle N+2; minimum issue interval 3 cycles.
REQ-022 Requester SHALL hold operands stable while valid&!ready; arbiter does not sample unselected requester.
REQ-023 ula_a/ula_b/ula_op SHALL hold the last registered values outside EXEC (no spurious toggling).
REQ-024 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-025 rst_n low at a clock edge: state=IDLE, rr pointer=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, operand/op registers=0.
REQ-026 Reset in EXEC or RESP SHALL drop the in-flight operation; no response issued for it.

Configuration
REQ-027 Macro ULA_ARB_STATS_EN defined: outputs grant_cnt0, grant_cnt1 (CNT_W each) count grants per requester, saturate at all-ones, reset to 0.
REQ-028 Macro undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-029 Reset, req0 a=5 b=3 op=4'b0110 -> req0_ready same cycle, 2 cycles later rsp_valid=1, rsp_id=0, rsp_result=2, rsp_flags=6'h2A.
REQ-030 Post-reset, req0 and req1 valid same cycle (req1 a=7 b=7 op=0) -> req0 served first; req1 granted in next IDLE, rsp_result=14, rsp_id=1.
REQ-031 Both requesters continuously valid for 6 grants -> grant order 0,1,0,1,0,1.
REQ-032 rsp_ready low 4 cycles in RESP -> rsp_* unchanged, both readys low; rsp_ready high -> IDLE next cycle.
REQ-033 rst_n low during EXEC -> next cycle rsp_valid=0, state IDLE, pointer 0, no response for dropped op.
REQ-034 With ULA_ARB_STATS_EN, CNT_W=2: 5 grants to req1 -> grant_cnt1=3 (saturated), grant_cnt0=0.

Source files
------------

// File: rtl/ula_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// Optional per-requester grant counters are built when ULA_ARB_STATS_EN is defined.
module ula_arbiter #(
  parameter int unsigned W     = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic [3:0]       req1_op,
  output logic [W-1:0]     ula_a,
  output logic [W-1:0]     ula_b,
  output logic [3:0]       ula_op,
  input  logic [W-1:0]     ula_result,
  input  logic [5:0]       ula_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_result,
`ifdef ULA_ARB_STATS_EN
  output logic [5:0]       rsp_flags,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`else
  output logic [5:0]       rsp_flags
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state;
  logic         rr;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [3:0]   op_q;
  logic         id_q;
  logic         grant0;
  logic         grant1;

  // Pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = req0_valid && (!req1_valid || !rr);
      grant1 = req1_valid && (!req0_valid || rr);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // ALU inputs come straight from the operand registers so they stay quiet outside EXEC.
  assign ula_a  = a_q;
  assign ula_b  = b_q;
  assign ula_op = op_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr         <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q   <= grant1 ? req1_a  : req0_a;
            b_q   <= grant1 ? req1_b  : req0_b;
            op_q  <= grant1 ? req1_op : req0_op;
            id_q  <= grant1;
            if (req0_valid && req1_valid)
              rr <= grant0;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= ula_result;
          rsp_flags  <= ula_flags;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ULA_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant0 && (grant_cnt0 != '1))
        grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (grant1 && (grant_cnt1 != '1))
        grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter with a behavioural ALU on the shared port.
module tb_ula_arbiter;
  localparam int unsigned W     = 64;
  localparam int unsigned CNT_W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] ula_a, ula_b, ula_result;
  logic [3:0]   ula_op;
  logic [5:0]   ula_flags;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_result;
  logic [5:0]   rsp_flags;
`ifdef ULA_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Reference ALU: subtract for op 4'b0110, add otherwise; flags {BGEU,BLTU,BGE,BLT,BNE,BEQ}.
  always_comb begin
    ula_result = (ula_op == 4'b0110) ? (ula_a - ula_b) : (ula_a + ula_b);
    ula_flags  = {ula_a >= ula_b, ula_a < ula_b,
                  $signed(ula_a) >= $signed(ula_b), $signed(ula_a) < $signed(ula_b),
                  ula_a != ula_b, ula_a == ula_b};
  end

  ula_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_result(ula_result), .ula_flags(ula_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result),
`ifdef ULA_ARB_STATS_EN
    .rsp_flags(rsp_flags),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`else
    .rsp_flags(rsp_flags)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = 64'd9; req0_b = 64'd1; req0_op = 4'b0110;
    req1_a = '0; req1_b = '0; req1_op = '0;
    req0_valid = 1'b1;
    cyc(); cyc(); cyc();
    do_reset();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%0h exp=0", rsp_id); end
    checks++; if (rsp_result !== 64'd0) begin errors++; $display("FAIL reset_rsp_result got=%0h exp=0", rsp_result); end
    checks++; if (rsp_flags !== 6'h00) begin errors++; $display("FAIL reset_rsp_flags got=%0h exp=0", rsp_flags); end
    checks++; if ({ula_a, ula_b, ula_op} !== '0) begin errors++; $display("FAIL reset_ula_regs got=%0h/%0h/%0h exp=0", ula_a, ula_b, ula_op); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_readys got=%b exp=00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_single();
    do_reset();
    req0_a = 64'd5; req0_b = 64'd3; req0_op = 4'b0110; req0_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_grant got=%b exp=10", {req0_ready, req1_ready}); end
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b1;
    #1;
    checks++; if ({ula_a, ula_b, ula_op} !== {64'd5, 64'd3, 4'b0110}) begin errors++; $display("FAIL single_ula_ops got=%0h/%0h/%0h exp=5/3/6", ula_a, ula_b, ula_op); end
    checks++; if ({rsp_valid, req1_ready} !== 2'b00) begin errors++; $display("FAIL single_exec_quiet got=%b exp=00", {rsp_valid, req1_ready}); end
    cyc();
    checks++; if ({rsp_valid, rsp_id, req1_ready} !== 3'b100) begin errors++; $display("FAIL single_rsp_hdr got=%b exp=100", {rsp_valid, rsp_id, req1_ready}); end
    checks++; if (rsp_result !== 64'd2) begin errors++; $display("FAIL single_rsp_result got=%0h exp=2", rsp_result); end
    checks++; if (rsp_flags !== 6'h2A) begin errors++; $display("FAIL single_rsp_flags got=%0h exp=2a", rsp_flags); end
    req1_valid = 1'b0; rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_done got=%0h exp=0", rsp_valid); end
  endtask

  task automatic test_contention();
    do_reset();
    req0_a = 64'd5; req0_b = 64'd3; req0_op = 4'b0110; req0_valid = 1'b1;
    req1_a = 64'd7; req1_b = 64'd7; req1_op = 4'b0000; req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL contend_first got=%b exp=10", {req0_ready, req1_ready}); end
    cyc();
    req0_valid = 1'b0;
    cyc();
    checks++; if ({rsp_valid, rsp_id} !== 2'b10 || rsp_result !== 64'd2) begin errors++; $display("FAIL contend_rsp0 got=%b/%0h exp=10/2", {rsp_valid, rsp_id}, rsp_result); end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL contend_second got=%b exp=01", {req0_ready, req1_ready}); end
    cyc();
    req1_valid = 1'b0;
    cyc();
    checks++; if ({rsp_valid, rsp_id} !== 2'b11) begin errors++; $display("FAIL contend_rsp1_hdr got=%b exp=11", {rsp_valid, rsp_id}); end
    checks++; if (rsp_result !== 64'd14 || rsp_flags !== 6'h29) begin errors++; $display("FAIL contend_rsp1_data got=%0h/%0h exp=e/29", rsp_result, rsp_flags); end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_ready;
    logic [63:0] exp_res;
    do_reset();
    req0_a = 64'd10; req0_b = 64'd4; req0_op = 4'b0110;
    req1_a = 64'd1;  req1_b = 64'd2; req1_op = 4'b0011;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_ready = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_res   = (i % 2 == 0) ? 64'd6 : 64'd3;
      #1;
      checks++; if ({req0_ready, req1_ready} !== exp_ready) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, {req0_ready, req1_ready}, exp_ready); end
      cyc(); cyc();
      checks++; if ({rsp_valid, rsp_id} !== {1'b1, exp_ready[0]} || rsp_result !== exp_res) begin errors++; $display("FAIL rr_rsp%0d got=%b/%0h exp=%b/%0h", i, {rsp_valid, rsp_id}, rsp_result, {1'b1, exp_ready[0]}, exp_res); end
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_idle_rsp_ready_ignored got=%0h exp=0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_a = 64'd100; req0_b = 64'd1; req0_op = 4'b0110; req0_valid = 1'b1;
    cyc();
    req0_valid = 1'b0;
    cyc();
    req0_a = 64'd55; req1_a = 64'd66; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({rsp_valid, rsp_id, req0_ready, req1_ready} !== 4'b1000) begin errors++; $display("FAIL bp_hold_hdr%0d got=%b exp=1000", i, {rsp_valid, rsp_id, req0_ready, req1_ready}); end
      checks++; if (rsp_result !== 64'd99 || rsp_flags !== 6'h2A) begin errors++; $display("FAIL bp_hold_data%0d got=%0h/%0h exp=63/2a", i, rsp_result, rsp_flags); end
      cyc();
    end
    req0_valid = 1'b0; rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    #1;
    checks++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin errors++; $display("FAIL bp_release got=%b exp=001", {rsp_valid, req0_ready, req1_ready}); end
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_exec();
    do_reset();
    req0_a = 64'd8; req0_b = 64'd2; req0_op = 4'b0000; req0_valid = 1'b1;
    req1_a = 64'd4; req1_b = 64'd4; req1_op = 4'b0000; req1_valid = 1'b1;
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checks++; if (rsp_valid !== 1'b0 || ula_a !== 64'd0) begin errors++; $display("FAIL rstexec_cleared got=%0h/%0h exp=0/0", rsp_valid, ula_a); end
    cyc(); cyc();
    checks++; if (rsp_valid !== 1'b0 || rsp_result !== 64'd0) begin errors++; $display("FAIL rstexec_no_rsp got=%0h/%0h exp=0/0", rsp_valid, rsp_result); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rstexec_ptr got=%b exp=10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

`ifdef ULA_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    req1_a = 64'd1; req1_b = 64'd1; req1_op = 4'b0000; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); cyc(); cyc();
    end
    req1_valid = 1'b0; rsp_ready = 1'b0;
    cyc();
    checks++; if (grant_cnt1 !== 2'd3 || grant_cnt0 !== 2'd0) begin errors++; $display("FAIL stats_cnt got=%0d/%0d exp=0/3", grant_cnt0, grant_cnt1); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
`ifdef ULA_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
